// File: rtl/elastic_fifo_thresh_pkg.sv
// Shared defaults and helpers for the parametrised elastic FIFO.
package elastic_fifo_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 5;
  localparam int AF_THRESH_DEF = 28;
  localparam int AE_THRESH_DEF = 4;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/elastic_fifo_thresh_if.sv
// Producer/consumer-facing signal bundle of the elastic FIFO.
interface elastic_fifo_thresh_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic              rd_en;
  logic              flush;
  logic              clr_err;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              buf_empty;
  logic              buf_full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   counter;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, rd_en, flush, clr_err, data_in,
    input  data_out, buf_empty, buf_full, almost_empty, almost_full,
           counter, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, flush, clr_err, data_in,
    output data_out, buf_empty, buf_full, almost_empty, almost_full,
           counter, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read.
// Latency: write visible on rdata the cycle after the write edge.
// Backpressure: none; caller gates we.
module fifo_mem_dp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/elastic_fifo_thresh.sv
// Elastic FIFO with thresholds, sticky errors and flush; FIFO_FWFT_EN selects first-word-fall-through read.
// Latency: write readable next cycle; registered read 1 cycle (0 cycles with FIFO_FWFT_EN).
// Backpressure: none; writes to a full FIFO are dropped (overflow), reads of an empty FIFO rejected (underflow).
module elastic_fifo_thresh
  import elastic_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  elastic_fifo_thresh_if.slave bus
);
  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0]   CNT_AE   = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] head;
  err_flags_t        err, err_nxt;
  logic              empty, full, rd_acc, wr_acc;

  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign rd_acc = bus.rd_en && !empty && !bus.flush;
  // A read in the same cycle frees a slot, so a full FIFO still takes the write.
  assign wr_acc = bus.wr_en && !bus.flush && (!full || rd_acc);

  fifo_mem_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Flush leaves the error flags alone and raises no new errors itself.
  always_comb begin
    err_nxt = err;
    if (bus.clr_err) err_nxt = '0;
    if (!bus.flush) begin
      if (bus.wr_en && !wr_acc) err_nxt.overflow  = 1'b1;
      if (bus.rd_en && !rd_acc) err_nxt.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= '0;
    else      err <= err_nxt;
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty ? '0 : head;
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           dout_q <= '0;
    else if (bus.flush) dout_q <= '0;
    else if (rd_acc)    dout_q <= head;
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.almost_empty = (count <= CNT_AE);
  assign bus.almost_full  = (count >= CNT_AF);
  assign bus.counter      = count;
  assign bus.overflow     = err.overflow;
  assign bus.underflow    = err.underflow;
endmodule

// File: tb/tb_elastic_fifo_thresh.sv
// Self-checking bench for elastic_fifo_thresh: directed scenarios plus randomized traffic against a queue model.
module tb_elastic_fifo_thresh;
  import elastic_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int AF    = 28;
  localparam int AE    = 4;
  localparam int DEPTH = depth_of(AW);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  elastic_fifo_thresh_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  elastic_fifo_thresh #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_dout();
`ifdef FIFO_FWFT_EN
    return (q.size() > 0) ? int'(q[0]) : 0;
`else
    return int'(m_dout);
`endif
  endfunction

  task automatic check_all();
    int n;
    n = q.size();
    chk("counter",      int'(bus.counter),      n);
    chk("buf_empty",    int'(bus.buf_empty),    int'(n == 0));
    chk("buf_full",     int'(bus.buf_full),     int'(n == DEPTH));
    chk("almost_empty", int'(bus.almost_empty), int'(n <= AE));
    chk("almost_full",  int'(bus.almost_full),  int'(n >= AF));
    chk("overflow",     int'(bus.overflow),     int'(m_ovf));
    chk("underflow",    int'(bus.underflow),    int'(m_unf));
    chk("data_out",     int'(bus.data_out),     exp_dout());
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input bit fl, input bit ce,
                            input logic [DW-1:0] din);
    bit ra, wa;
    if (ce) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (fl) begin
      q.delete();
      m_dout = '0;
    end else begin
      ra = rd && (q.size() > 0);
      wa = wr && ((q.size() < DEPTH) || ra);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
      if (wr && !wa) m_ovf = 1'b1;
      if (rd && !ra) m_unf = 1'b1;
    end
  endtask

  // Called just after a rising edge: drive, let the edge happen, then compare.
  task automatic step(input bit wr, input bit rd, input bit fl, input bit ce,
                      input logic [DW-1:0] din);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.flush   = fl;
    bus.clr_err = ce;
    bus.data_in = din;
    @(posedge clk);
    model_step(wr, rd, fl, ce, din);
    #1;
    check_all();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wp, rp;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    bus.data_in = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_counter", int'(bus.counter), 0);
    chk("reset_empty",   int'(bus.buf_empty), 1);
    chk("reset_ae",      int'(bus.almost_empty), 1);
    chk("reset_full",    int'(bus.buf_full), 0);
    chk("reset_af",      int'(bus.almost_full), 0);
    chk("reset_dout",    int'(bus.data_out), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Async reset mid-stream with counter=7 and underflow set
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
    step(0, 1, 0, 0, 8'h00);
    chk("pre_reset_counter", int'(bus.counter), 7);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("areset_counter",   int'(bus.counter), 0);
    chk("areset_empty",     int'(bus.buf_empty), 1);
    chk("areset_ae",        int'(bus.almost_empty), 1);
    chk("areset_dout",      int'(bus.data_out), 0);
    chk("areset_underflow", int'(bus.underflow), 0);
    chk("areset_overflow",  int'(bus.overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 0, 8'(i));
      if (i == AF - 2) chk("af_before_28", int'(bus.almost_full), 0);
      if (i == AF - 1) chk("af_at_28", int'(bus.almost_full), 1);
    end
    chk("fill_full",    int'(bus.buf_full), 1);
    chk("fill_counter", int'(bus.counter), 32);
    step(1, 0, 0, 0, 8'hAA);
    chk("ovf_flag",    int'(bus.overflow), 1);
    chk("ovf_counter", int'(bus.counter), 32);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef FIFO_FWFT_EN
      chk("drain_head", int'(bus.data_out), i);
      step(0, 1, 0, 0, 8'h00);
`else
      step(0, 1, 0, 0, 8'h00);
      chk("drain_dout", int'(bus.data_out), i);
`endif
      if (i == DEPTH - AE - 1) chk("ae_at_4", int'(bus.almost_empty), 1);
      if (i == DEPTH - AE - 2) chk("ae_at_5", int'(bus.almost_empty), 0);
    end

    // Underflow then clear
    step(0, 1, 0, 0, 8'h00);
    chk("unf_flag",    int'(bus.underflow), 1);
    chk("unf_counter", int'(bus.counter), 0);
`ifdef FIFO_FWFT_EN
    chk("unf_dout", int'(bus.data_out), 0);
`else
    chk("unf_dout", int'(bus.data_out), 31);
`endif
    step(0, 0, 0, 1, 8'h00);
    chk("clr_unf", int'(bus.underflow), 0);
    chk("clr_ovf", int'(bus.overflow), 0);

    // Simultaneous write+read while full
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 8'(8'h80 + i));
`ifdef FIFO_FWFT_EN
    chk("full_wr_rd_head", int'(bus.data_out), 8'h80);
    step(1, 1, 0, 0, 8'h55);
`else
    step(1, 1, 0, 0, 8'h55);
    chk("full_wr_rd_dout", int'(bus.data_out), 8'h80);
`endif
    chk("full_wr_rd_counter", int'(bus.counter), 32);
    chk("full_wr_rd_ovf",     int'(bus.overflow), 0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0, 0, 8'h00);
`ifdef FIFO_FWFT_EN
    chk("last_is_55", int'(bus.data_out), 8'h55);
    step(0, 1, 0, 0, 8'h00);
`else
    step(0, 1, 0, 0, 8'h00);
    chk("last_is_55", int'(bus.data_out), 8'h55);
`endif

    // Flush with a concurrent write
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    step(1, 0, 1, 0, 8'h77);
    chk("flush_counter", int'(bus.counter), 0);
    chk("flush_empty",   int'(bus.buf_empty), 1);
    step(1, 0, 0, 0, 8'h12);
`ifdef FIFO_FWFT_EN
    chk("post_flush_head", int'(bus.data_out), 8'h12);
    step(0, 1, 0, 0, 8'h00);
`else
    step(0, 1, 0, 0, 8'h00);
    chk("post_flush_dout", int'(bus.data_out), 8'h12);
`endif

`ifdef FIFO_FWFT_EN
    step(1, 0, 0, 0, 8'h3C);
    chk("fwft_head", int'(bus.data_out), 8'h3C);
    step(0, 1, 0, 0, 8'h00);
    chk("fwft_pop_dout",  int'(bus.data_out), 0);
    chk("fwft_pop_empty", int'(bus.buf_empty), 1);
`endif

    // Randomized traffic with phases biased toward filling, balanced, draining
    wp = 50;
    rp = 50;
    for (int n = 0; n < 2000; n++) begin
      if (n % 40 == 0) begin
        case ($urandom_range(0, 2))
          0:       begin wp = 85; rp = 20; end
          1:       begin wp = 50; rp = 50; end
          default: begin wp = 20; rp = 85; end
        endcase
      end
      step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
           8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
